// File: rtl/regs_if.sv
`default_nettype none
// ============================================================================
// regs_if : writeback, decode-read and debug signals of the register file
// Revision: 1.0
// ============================================================================
interface regs_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_i;
  logic              rd_wen_i;
  logic [ADDR_W-1:0] reg1_raddr_i;
  logic [DATA_W-1:0] reg1_rdata_o;
  logic [ADDR_W-1:0] reg2_raddr_i;
  logic [DATA_W-1:0] reg2_rdata_o;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_wdata_i;
  logic              dbg_wen_i;
  logic              dbg_ready_o;
  logic              dbg_ack_o;
  logic [DATA_W-1:0] dbg_rdata_o;

  modport master (
    output rd_addr_i, rd_data_i, rd_wen_i,
    output reg1_raddr_i, reg2_raddr_i,
    output dbg_addr_i, dbg_wdata_i, dbg_wen_i,
    input  reg1_rdata_o, reg2_rdata_o,
    input  dbg_ready_o, dbg_ack_o, dbg_rdata_o
  );

  modport slave (
    input  rd_addr_i, rd_data_i, rd_wen_i,
    input  reg1_raddr_i, reg2_raddr_i,
    input  dbg_addr_i, dbg_wdata_i, dbg_wen_i,
    output reg1_rdata_o, reg2_rdata_o,
    output dbg_ready_o, dbg_ack_o, dbg_rdata_o
  );
endinterface
`default_nettype wire

// File: rtl/regs.sv
`default_nettype none
// ============================================================================
// regs : integer register file with WB->ID bypass and a deferring debug port
// Revision: 1.0
// ============================================================================
module regs #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  regs_if.slave     bus
);

  logic [DATA_W-1:0] rf [REG_NUM];

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic              wb_we;
  logic              dbg_accept;
  logic              dbg_now;
  logic              dbg_defer;
  logic              pend_commit;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_waddr;
  logic [DATA_W-1:0] dbg_wval;
  logic              hit1;
  logic              hit2;
  logic              hitd;
  logic [DATA_W-1:0] dbg_rd_val;

  assign wb_we       = bus.rd_wen_i && (bus.rd_addr_i != '0);
  assign dbg_accept  = bus.dbg_wen_i && !pend_valid;
  assign dbg_now     = dbg_accept && !bus.rd_wen_i;
  assign dbg_defer   = dbg_accept && bus.rd_wen_i;
  assign pend_commit = pend_valid && !bus.rd_wen_i;

  // A debug write only ever reaches the array in a cycle with no pipeline write.
  assign dbg_waddr = pend_commit ? pend_addr : bus.dbg_addr_i;
  assign dbg_wval  = pend_commit ? pend_data : bus.dbg_wdata_i;
  assign dbg_we    = (pend_commit || dbg_now) && (dbg_waddr != '0);

  assign hit1 = bus.rd_wen_i && (bus.rd_addr_i == bus.reg1_raddr_i);
  assign hit2 = bus.rd_wen_i && (bus.rd_addr_i == bus.reg2_raddr_i);
  assign hitd = bus.rd_wen_i && (bus.rd_addr_i == bus.dbg_addr_i);

  assign bus.reg1_rdata_o = (bus.reg1_raddr_i == '0) ? '0 :
                            hit1 ? bus.rd_data_i : rf[bus.reg1_raddr_i];
  assign bus.reg2_rdata_o = (bus.reg2_raddr_i == '0) ? '0 :
                            hit2 ? bus.rd_data_i : rf[bus.reg2_raddr_i];
  assign dbg_rd_val       = (bus.dbg_addr_i == '0) ? '0 :
                            hitd ? bus.rd_data_i : rf[bus.dbg_addr_i];

  assign bus.dbg_ready_o = !pend_valid;
  assign bus.dbg_ack_o   = dbg_ack;
  assign bus.dbg_rdata_o = dbg_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (wb_we) begin
        rf[bus.rd_addr_i] <= bus.rd_data_i;
      end
      if (dbg_we) begin
        rf[dbg_waddr] <= dbg_wval;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      dbg_ack    <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      if (pend_commit) begin
        pend_valid <= 1'b0;
      end else if (dbg_defer) begin
        pend_valid <= 1'b1;
        pend_addr  <= bus.dbg_addr_i;
        pend_data  <= bus.dbg_wdata_i;
      end
      // x0 writes are dropped above but still acknowledged here.
      dbg_ack   <= pend_commit || dbg_now;
      dbg_rdata <= dbg_rd_val;
    end
  end

endmodule
`default_nettype wire

// File: doc/regs.md
Name: regs

Overview:
- General-purpose register file for the single-issue RISC-V core, sitting directly downstream of the execute stage.
- Commits the execute stage's writeback (address, data, enable) and serves two combinational read ports to decode.
- Same-cycle write-to-read bypass removes the WB→ID hazard.
- A debug port allows register inspection and modification; a one-entry buffer defers debug writes that collide with pipeline writes.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hardwired to zero.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W == REG_NUM.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr_i  in  ADDR_W  writeback destination from execute stage.
- rd_data_i  in  DATA_W  writeback data from execute stage.
- rd_wen_i  in  1  writeback enable from execute stage.
- reg1_raddr_i  in  ADDR_W  decode read port 1 address.
- reg1_rdata_o  out  DATA_W  decode read port 1 data, combinational.
- reg2_raddr_i  in  ADDR_W  decode read port 2 address.
- reg2_rdata_o  out  DATA_W  decode read port 2 data, combinational.
- dbg_addr_i  in  ADDR_W  debug register address.
- dbg_wdata_i  in  DATA_W  debug write data.
- dbg_wen_i  in  1  debug write request.
- dbg_ready_o  out  1  debug write accepted this cycle when high.
- dbg_ack_o  out  1  one-cycle pulse after a debug write commits.
- dbg_rdata_o  out  DATA_W  registered debug read data.

Behaviour:
- Reset (async, rst=1):
  - All registers clear to 0.
  - Pending debug buffer clears (valid=0); any in-flight debug write is dropped without ack.
  - dbg_ack_o=0, dbg_rdata_o=0, dbg_ready_o=1 while rst is high.
- Pipeline write: at posedge, if rd_wen_i=1 and rd_addr_i!=0, regs[rd_addr_i] <= rd_data_i. Writes to x0 are discarded.
- Read ports (each independent):
  - Address 0 → 0.
  - Else, if rd_wen_i=1 and rd_addr_i==raddr → rd_data_i (bypass).
  - Else → regs[raddr].
  - No bypass from the pending debug buffer.
- dbg_ready_o = !pend_valid (combinational).
- Debug write accepted when dbg_wen_i & dbg_ready_o:
  - If rd_wen_i=0 in that cycle: commits at that edge.
  - If rd_wen_i=1: addr/data captured into the pending buffer, pend_valid <= 1.
- Pending commit: at any edge with pend_valid=1 and rd_wen_i=0, regs[pend_addr] <= pend_data and pend_valid <= 0.
  - Pending entry waits indefinitely while rd_wen_i stays high; dbg_ready_o stays low.
- Pipeline writes always take priority over debug writes. A debug write is ordered at its commit edge and may overwrite a newer pipeline value to the same register (decided; the debugger halts the core before writing).
- Debug writes to x0 are discarded but still acked.
- dbg_ack_o: high for exactly the one cycle following the commit edge, for both immediate and deferred commits.
- Debug read: every edge, dbg_rdata_o <= (dbg_addr_i==0) ? 0 : (rd_wen_i && rd_addr_i==dbg_addr_i) ? rd_data_i : regs[dbg_addr_i].
  - Latency: 1 cycle.
  - Updates regardless of dbg_wen_i.

Test Plan:
- Reset, then read all 32 addresses on both ports → all 0; dbg_ready_o=1, dbg_ack_o=0.
- rd_wen_i=1, rd_addr_i=5, rd_data_i=0x1234_5678 with reg1_raddr_i=5 in the same cycle → reg1_rdata_o=0x1234_5678 combinationally; next cycle with rd_wen_i=0 still 0x1234_5678.
- Write x0=0xFFFF_FFFF via the pipeline and via debug → reads of x0 return 0; debug ack still pulses.
- dbg_wen_i=1, addr 7, data 0xA5A5_0001 while rd_wen_i=1 (addr 3) for 3 cycles:
  - Accepted on cycle 0; dbg_ready_o=0 for cycles 1–3.
  - Commit at the first rd_wen_i=0 edge; dbg_ack_o pulses the next cycle.
  - x7=0xA5A5_0001, x3 holds the pipeline value.
- Debug read addr 9 while the pipeline writes x9=0xDEAD_BEEF the same cycle → dbg_rdata_o=0xDEAD_BEEF one cycle later.
- Assert rst while the pending buffer holds addr 4, data 0x55 → x4=0, no dbg_ack_o pulse, dbg_ready_o=1 immediately.
